// File: rtl/pattern_pkg.sv
// Shared types and constants for the serial pattern path (transmitter and
// detectors).
package pattern_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/pattern_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// serial bit period.
module pattern_bit_timer
   import pattern_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign bit_end = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, optional even parity,
// stop bit(s). The idle-high line gives downstream detectors a 1->0 start edge.
module pattern_serial_tx
   import pattern_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   localparam int BCW = 6;
   localparam logic [BCW-1:0] LAST_DATA = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

   tx_state_t        state, state_nxt;
   logic [BCW-1:0]   bit_cnt;
   logic [WIDTH-1:0] shift_reg, shift_nxt;
   logic             par;
   logic             bit_end;
   logic             xfer;

   function automatic logic even_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   function automatic logic tx_level(input tx_state_t s, input logic dbit,
                                     input logic pbit);
      case (s)
         TX_START:  return 1'b0;
         TX_DATA:   return dbit;
         TX_PARITY: return pbit;
         default:   return TX_IDLE_LEVEL;
      endcase
   endfunction

   assign din_ready = (state == TX_IDLE);
   assign busy      = (state != TX_IDLE);
   assign xfer      = din_valid && din_ready;

   // Timer held cleared in IDLE; every other transition lands on a bit_end,
   // where the timer wraps to 0 by itself.
   pattern_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == TX_IDLE),
      .bit_end(bit_end)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE:   if (xfer) state_nxt = TX_START;
         TX_START:  if (bit_end) state_nxt = TX_DATA;
         TX_DATA:
            if (bit_end && bit_cnt == LAST_DATA)
               state_nxt = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
         TX_PARITY: if (bit_end) state_nxt = TX_STOP;
         TX_STOP:   if (bit_end && bit_cnt == LAST_STOP) state_nxt = TX_IDLE;
         default:   state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      shift_nxt = shift_reg;
      if (xfer) begin
         shift_nxt = din;
      end else if (state == TX_DATA && bit_end) begin
         shift_nxt = shift_reg >> 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= TX_IDLE;
         bit_cnt <= '0;
         tx      <= TX_IDLE_LEVEL;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         // tx is registered from the next-state view so it changes on the
         // same edge as the state it belongs to.
         tx    <= tx_level(state_nxt, shift_nxt[0], par);
         done  <= (state == TX_STOP) && (state_nxt == TX_IDLE);
         if (state_nxt != state) begin
            bit_cnt <= '0;
         end else if (bit_end && (state == TX_DATA || state == TX_STOP)) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      shift_reg <= shift_nxt;
      if (xfer) begin
         par <= even_parity(din);
      end
   end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Scoreboard bench for pattern_serial_tx: one plain instance and one with
// parity and 4x bit stretching.
module tb_pattern_serial_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] din = 8'h00;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       ready_a, tx_a, busy_a, done_a;
   logic       ready_b, tx_b, busy_b, done_b;
   logic       sel = 1'b0;
   logic       ready_s, tx_s, busy_s, done_s;
   logic       q[$];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   pattern_serial_tx #(
      .WIDTH(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_EN(0)
   ) u_dut_a (
      .clk(clk), .reset(reset), .din(din), .din_valid(valid_a),
      .din_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   pattern_serial_tx #(
      .WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .din(din), .din_valid(valid_b),
      .din_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   assign ready_s = sel ? ready_b : ready_a;
   assign tx_s    = sel ? tx_b    : tx_a;
   assign busy_s  = sel ? busy_b  : busy_a;
   assign done_s  = sel ? done_b  : done_a;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_valid(input logic v);
      if (sel) valid_b = v;
      else     valid_a = v;
   endtask

   // Expected per-cycle line levels for one frame.
   task automatic push_frame(input logic [7:0] w, input int cpb, input bit pe);
      for (int c = 0; c < cpb; c++) q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
         for (int c = 0; c < cpb; c++) q.push_back(w[b]);
      if (pe)
         for (int c = 0; c < cpb; c++) q.push_back(^w);
      for (int c = 0; c < cpb; c++) q.push_back(1'b1);
   endtask

   // Entered at the negedge of frame cycle 1; leaves at the negedge of the
   // idle cycle that follows the frame.
   task automatic frame_body(input bit disturb);
      int f;
      f = q.size();
      for (int i = 0; i < f; i++) begin
         chk("tx", tx_s, q.pop_front());
         chk("busy", busy_s, 1);
         chk("ready_low", ready_s, 0);
         chk("done_low", done_s, 0);
         if (disturb) begin
            din = 8'($urandom);
            set_valid((i % 2 == 0) && (i < f - 1));
         end
         @(negedge clk);
      end
      chk("done_pulse", done_s, 1);
      chk("idle_tx", tx_s, 1);
      chk("idle_ready", ready_s, 1);
      chk("idle_busy", busy_s, 0);
   endtask

   task automatic send(input logic [7:0] w, input int cpb, input bit pe,
                       input bit disturb);
      din = w;
      set_valid(1'b1);
      chk("accept_ready", ready_s, 1);
      push_frame(w, cpb, pe);
      @(negedge clk);
      set_valid(1'b0);
      din = ~w;
      frame_body(disturb);
      @(negedge clk);
      chk("post_done", done_s, 0);
      chk("post_busy", busy_s, 0);
      chk("post_tx", tx_s, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      // Asynchronous reset between clock edges.
      #2 reset = 1'b1;
      #1;
      chk("rst_tx_a", tx_a, 1);
      chk("rst_ready_a", ready_a, 1);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_tx_b", tx_b, 1);
      chk("rst_ready_b", ready_b, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("noval_tx", tx_a, 1);
         chk("noval_done", done_a, 0);
      end

      sel = 1'b0;
      send(8'hA5, 1, 1'b0, 1'b0);

      sel = 1'b1;
      send(8'h07, 4, 1'b1, 1'b0);
      send(8'h03, 4, 1'b1, 1'b0);
      send(8'hA5, 4, 1'b1, 1'b1);

      // Back-to-back with din_valid held high.
      sel = 1'b0;
      din = 8'h00;
      set_valid(1'b1);
      chk("b2b_ready1", ready_s, 1);
      push_frame(8'h00, 1, 1'b0);
      @(negedge clk);
      din = 8'hFF;
      frame_body(1'b0);
      push_frame(8'hFF, 1, 1'b0);
      @(negedge clk);
      set_valid(1'b0);
      frame_body(1'b0);
      @(negedge clk);
      chk("b2b_no_third", busy_s, 0);
      chk("b2b_done_low", done_s, 0);

      send(8'h96, 1, 1'b0, 1'b1);

      // Reset during data bit 3 of 8'h5A.
      din = 8'h5A;
      set_valid(1'b1);
      chk("mid_ready", ready_s, 1);
      push_frame(8'h5A, 1, 1'b0);
      @(negedge clk);
      set_valid(1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("mid_tx", tx_s, q.pop_front());
         if (i < 4) @(negedge clk);
      end
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_tx", tx_a, 1);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_ready", ready_a, 1);
      chk("mid_rst_done", done_a, 0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("after_rst_done", done_a, 0);
      chk("after_rst_tx", tx_a, 1);
      send(8'h3C, 1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
